// File: rtl/adder_pkg.sv
// adder_pkg: shared nibble width and FSM state type for nibble_serial_adder.
package adder_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/cla4_core.sv
// cla4_core: combinational 4-bit carry-lookahead slice; c3 is the carry into bit 3.
module cla4_core (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);
    logic [3:0] g, p;
    logic       c1, c2;
    assign g  = a & b;
    assign p  = a ^ b;
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (&p & ci);
    assign s  = p ^ {c3, c2, c1, ci};
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder reusing one 4-bit CLA slice, one nibble per clock.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_t                  state, next_state;
    logic [WIDTH-1:0]        a_reg, b_reg;
    logic [IW-1:0]           idx;
    logic                    carry;
    logic [NIBBLE_W-1:0]     s;
    logic                    co, c3;

    cla4_core u_cla (
        .a  (a_reg[NIBBLE_W*idx +: NIBBLE_W]),
        .b  (b_reg[NIBBLE_W*idx +: NIBBLE_W]),
        .ci (carry),
        .s  (s),
        .co (co),
        .c3 (c3)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = in_valid ? RUN : IDLE;
            RUN:     next_state = (idx == LAST) ? DONE : RUN;
            DONE:    next_state = out_ready ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next_state;

    // The carry between nibbles only travels through the carry register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            carry <= 1'b0;
            idx   <= '0;
        end else if (state == IDLE && in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum[NIBBLE_W*idx +: NIBBLE_W] <= s;
            carry <= co;
            idx   <= (idx == LAST) ? '0 : idx + 1'b1;
            if (idx == LAST) cout <= co;
        end
    end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    always_ff @(posedge clk or posedge rst)
        if (rst)                             ovf <= 1'b0;
        else if (state == RUN && idx == LAST) ovf <= c3 ^ co;
`else
    logic unused_c3;
    assign unused_c3 = c3;
`endif
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed self-checking bench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;
    localparam int W = 16;

    logic         clk = 1'b0, rst = 1'b1;
    logic         in_valid = 1'b0, cin = 1'b0, out_ready = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, cout;
    logic [W-1:0] sum;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif
    int n_cmp = 0, n_err = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic eo, input int hold);
        int n;
        n = 0;
        check("idle_ready", 32'(in_ready), 1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_ready", 32'(in_ready), 0);
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 4);
        check("sum", 32'(sum), 32'(es));
        check("cout", 32'(cout), 32'(ec));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unexpected x in ovf expectation");
`endif
        for (int i = 0; i < hold; i++) begin
            a = 16'h1111; b = 16'h2222; in_valid = (i == 2);
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 1);
            check("bp_ready", 32'(in_ready), 0);
            check("bp_sum", 32'(sum), 32'(es));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drop_valid", 32'(out_valid), 0);
        check("ret_ready", 32'(in_ready), 1);
    endtask

    initial begin
        #2;
        check("rst_ready", 32'(in_ready), 1);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_op(16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op(16'h000B, 16'h0006, 1'b0, 16'h0011, 1'b0, 1'b0, 0);
        run_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 0);
        run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 5);
        run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);
        a = 16'h1234; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_ready", 32'(in_ready), 1);
        check("midrst_sum", 32'(sum), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_valid", 32'(out_valid), 0);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
